// File: rtl/triangle_rasterizer_if.sv
// Triangle hand-off bus from primitive_assembler to triangle_rasterizer.
// Vertex and box entries are indexed [0]=x, [1]=y.
interface triangle_rasterizer_if #(
    parameter int DW = 12,
    parameter int ZW = 12
);
    logic                 i_dv;
    logic                 o_ready;
    logic signed [DW-1:0] i_vertex_pixel [3][2];
    logic        [ZW-1:0] i_vertex_z     [3];
    logic signed [DW-1:0] i_bb_tl        [2];
    logic signed [DW-1:0] i_bb_br        [2];

    modport master (
        output i_dv, i_vertex_pixel, i_vertex_z, i_bb_tl, i_bb_br,
        input  o_ready
    );

    modport slave (
        input  i_dv, i_vertex_pixel, i_vertex_z, i_bb_tl, i_bb_br,
        output o_ready
    );
endinterface

// File: rtl/triangle_rasterizer.sv
// Scans a triangle's clamped bounding box row-major, one pixel per clk, using
// incrementally stepped edge functions; emits one fragment per covered pixel.
module triangle_rasterizer #(
    parameter  int IV_DATAWIDTH      = 12,
    parameter  int IV_DEPTH_FRACBITS = 12,
    localparam int EW                = 2 * IV_DATAWIDTH + 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    triangle_rasterizer_if.slave           s_tri,
    input  logic                           i_frag_ready,
    output logic                           o_frag_dv,
    output logic signed [IV_DATAWIDTH-1:0] o_frag_x,
    output logic signed [IV_DATAWIDTH-1:0] o_frag_y,
    output logic signed [EW-1:0]           o_w        [3],
    output logic signed [EW-1:0]           o_area,
    output logic [IV_DEPTH_FRACBITS-1:0]   o_vertex_z [3],
    output logic                           o_busy,
    output logic                           o_tri_done
);
    localparam int DW = IV_DATAWIDTH;
    localparam int ZW = IV_DEPTH_FRACBITS;

    typedef enum logic [2:0] {
        IDLE,
        SETUP_DELTA,
        SETUP_EDGE,
        SCAN,
        DRAIN
    } state_t;

    state_t               r_state;
    logic signed [DW-1:0] r_vx [3];
    logic signed [DW-1:0] r_vy [3];
    logic signed [DW-1:0] r_tlx, r_tly, r_brx, r_bry;
    logic signed [DW-1:0] r_x, r_y;
    logic        [ZW-1:0] r_z [3];
    logic signed [EW-1:0] r_dx [3];
    logic signed [EW-1:0] r_dy [3];
    logic signed [EW-1:0] r_w [3];
    logic signed [EW-1:0] r_row [3];
    logic signed [EW-1:0] r_area;

    logic                 r_frag_dv;
    logic signed [DW-1:0] r_frag_x, r_frag_y;
    logic signed [EW-1:0] r_fw [3];

    logic signed [EW-1:0] w_area_raw;
    logic signed [EW-1:0] w_dx [3];
    logic signed [EW-1:0] w_dy [3];
    logic signed [EW-1:0] w_e0 [3];
    logic                 w_neg, w_skip, w_inside, w_slot_free, w_adv;

    function automatic logic signed [EW-1:0] sx(input logic signed [DW-1:0] v);
        return EW'(v);
    endfunction

    // Edge i runs from vertex (i+1)%3 to (i+2)%3, so w0 = v1->v2, w1 = v2->v0, w2 = v0->v1.
    always_comb begin
        w_area_raw = (sx(r_vx[2]) - sx(r_vx[1])) * (sx(r_vy[0]) - sx(r_vy[1]))
                   - (sx(r_vy[2]) - sx(r_vy[1])) * (sx(r_vx[0]) - sx(r_vx[1]));
        for (int unsigned i = 0; i < 3; i++) begin
            w_dx[i] = sx(r_vy[(i+1)%3]) - sx(r_vy[(i+2)%3]);
            w_dy[i] = sx(r_vx[(i+2)%3]) - sx(r_vx[(i+1)%3]);
            w_e0[i] = r_dy[i] * (sx(r_tly) - sx(r_vy[(i+1)%3]))
                    + r_dx[i] * (sx(r_tlx) - sx(r_vx[(i+1)%3]));
        end
    end

    assign w_neg       = r_area[EW-1];
    assign w_skip      = (r_area == '0) || (r_tlx > r_brx) || (r_tly > r_bry);
    assign w_inside    = !r_w[0][EW-1] && !r_w[1][EW-1] && !r_w[2][EW-1];
    assign w_slot_free = !r_frag_dv || i_frag_ready;
    assign w_adv       = !w_inside || w_slot_free;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_frag_dv <= 1'b0;
            r_frag_x  <= '0;
            r_frag_y  <= '0;
            r_tlx     <= '0;
            r_tly     <= '0;
            r_brx     <= '0;
            r_bry     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_area    <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_vx[i]  <= '0;
                r_vy[i]  <= '0;
                r_z[i]   <= '0;
                r_dx[i]  <= '0;
                r_dy[i]  <= '0;
                r_w[i]   <= '0;
                r_row[i] <= '0;
                r_fw[i]  <= '0;
            end
        end else begin
            if (r_frag_dv && i_frag_ready)
                r_frag_dv <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (s_tri.i_dv) begin
                        for (int unsigned i = 0; i < 3; i++) begin
                            r_vx[i] <= s_tri.i_vertex_pixel[i][0];
                            r_vy[i] <= s_tri.i_vertex_pixel[i][1];
                            r_z[i]  <= s_tri.i_vertex_z[i];
                        end
                        r_tlx   <= s_tri.i_bb_tl[0];
                        r_tly   <= s_tri.i_bb_tl[1];
                        r_brx   <= s_tri.i_bb_br[0];
                        r_bry   <= s_tri.i_bb_br[1];
                        r_state <= SETUP_DELTA;
                    end
                end
                SETUP_DELTA: begin
                    for (int unsigned i = 0; i < 3; i++) begin
                        r_dx[i] <= w_dx[i];
                        r_dy[i] <= w_dy[i];
                    end
                    r_area  <= w_area_raw;
                    r_state <= SETUP_EDGE;
                end
                SETUP_EDGE: begin
                    // Clockwise triangles are flipped so coverage is always w >= 0.
                    for (int unsigned i = 0; i < 3; i++) begin
                        r_w[i]   <= w_neg ? -w_e0[i] : w_e0[i];
                        r_row[i] <= w_neg ? -w_e0[i] : w_e0[i];
                        r_dx[i]  <= w_neg ? -r_dx[i] : r_dx[i];
                        r_dy[i]  <= w_neg ? -r_dy[i] : r_dy[i];
                    end
                    r_area  <= w_neg ? -r_area : r_area;
                    r_x     <= r_tlx;
                    r_y     <= r_tly;
                    r_state <= w_skip ? DRAIN : SCAN;
                end
                SCAN: begin
                    if (w_adv) begin
                        if (w_inside) begin
                            r_frag_dv <= 1'b1;
                            r_frag_x  <= r_x;
                            r_frag_y  <= r_y;
                            for (int unsigned i = 0; i < 3; i++)
                                r_fw[i] <= r_w[i];
                        end
                        if (r_x != r_brx) begin
                            r_x <= r_x + DW'(1);
                            for (int unsigned i = 0; i < 3; i++)
                                r_w[i] <= r_w[i] + r_dx[i];
                        end else if (r_y != r_bry) begin
                            r_x <= r_tlx;
                            r_y <= r_y + DW'(1);
                            for (int unsigned i = 0; i < 3; i++) begin
                                r_row[i] <= r_row[i] + r_dy[i];
                                r_w[i]   <= r_row[i] + r_dy[i];
                            end
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_slot_free)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_tri.o_ready = (r_state == IDLE);
    assign o_busy        = (r_state != IDLE);
    assign o_tri_done    = (r_state == DRAIN) && w_slot_free;
    assign o_frag_dv     = r_frag_dv;
    assign o_frag_x      = r_frag_x;
    assign o_frag_y      = r_frag_y;
    assign o_w           = r_fw;
    assign o_area        = r_area;
    assign o_vertex_z    = r_z;
endmodule

// File: tb/tb_triangle_rasterizer.sv
// Directed bench for triangle_rasterizer: coverage, winding, degenerate/empty
// boxes, downstream back-pressure and mid-triangle reset.
module tb_triangle_rasterizer;
    localparam int DW = 12;
    localparam int ZW = 12;
    localparam int EW = 2 * DW + 4;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 i_frag_ready;
    logic                 o_frag_dv, o_busy, o_tri_done;
    logic signed [DW-1:0] o_frag_x, o_frag_y;
    logic signed [EW-1:0] o_w [3];
    logic signed [EW-1:0] o_area;
    logic        [ZW-1:0] o_vertex_z [3];

    triangle_rasterizer_if #(.DW(DW), .ZW(ZW)) tri_bus ();

    triangle_rasterizer #(
        .IV_DATAWIDTH     (DW),
        .IV_DEPTH_FRACBITS(ZW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .s_tri       (tri_bus),
        .i_frag_ready(i_frag_ready),
        .o_frag_dv   (o_frag_dv),
        .o_frag_x    (o_frag_x),
        .o_frag_y    (o_frag_y),
        .o_w         (o_w),
        .o_area      (o_area),
        .o_vertex_z  (o_vertex_z),
        .o_busy      (o_busy),
        .o_tri_done  (o_tri_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     x, y, c;
        longint w0, w1, w2, area;
    } frag_t;

    frag_t fq[$];
    frag_t cur, snap;
    int    cyc = 0;
    int    done_cnt = 0, done_cyc = -1, stall_cnt = 0, stab_err = 0;
    bit    hold = 1'b0;
    int    n_cmp = 0, n_bad = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: samples on the falling edge, logs accepted fragments and done pulses.
    initial forever begin
        @(negedge clk);
        if (rstn) begin
            cur.x = int'(o_frag_x);
            cur.y = int'(o_frag_y);
            cur.c = cyc;
            cur.w0 = longint'(o_w[0]);
            cur.w1 = longint'(o_w[1]);
            cur.w2 = longint'(o_w[2]);
            cur.area = longint'(o_area);
            if (hold && o_frag_dv && (cur.x != snap.x || cur.y != snap.y ||
                cur.w0 != snap.w0 || cur.w1 != snap.w1 || cur.w2 != snap.w2))
                stab_err++;
            hold = o_frag_dv && !i_frag_ready;
            snap = cur;
            if (hold) stall_cnt++;
            if (o_frag_dv && i_frag_ready) fq.push_back(cur);
            if (o_tri_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            hold = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2, input int tlx, input int tly,
                            input int brx, input int bry, output int t);
        int n = 0;
        while (!tri_bus.o_ready && n < 100) begin
            tick();
            n++;
        end
        check("send o_ready", longint'(tri_bus.o_ready), 1);
        tri_bus.i_vertex_pixel[0][0] = DW'(x0);
        tri_bus.i_vertex_pixel[0][1] = DW'(y0);
        tri_bus.i_vertex_pixel[1][0] = DW'(x1);
        tri_bus.i_vertex_pixel[1][1] = DW'(y1);
        tri_bus.i_vertex_pixel[2][0] = DW'(x2);
        tri_bus.i_vertex_pixel[2][1] = DW'(y2);
        tri_bus.i_bb_tl[0] = DW'(tlx);
        tri_bus.i_bb_tl[1] = DW'(tly);
        tri_bus.i_bb_br[0] = DW'(brx);
        tri_bus.i_bb_br[1] = DW'(bry);
        tri_bus.i_dv = 1'b1;
        t = cyc;
        tick();
        tri_bus.i_dv = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int start_cnt);
        int n = 0;
        while (done_cnt == start_cnt && n < 300) begin
            tick();
            n++;
        end
        check({tag, " done seen"}, longint'(done_cnt - start_cnt), 1);
    endtask

    // Triangle with legs of 4 at the origin: covered iff x+y<=4,
    // w0 = 16-4(x+y); the other two weights are 4x and 4y in winding order.
    task automatic check_list(input string nm, input int first_c, input bit swapped);
        int ex[$], ey[$];
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4; x++)
                if (x + y <= 4) begin
                    ex.push_back(x);
                    ey.push_back(y);
                end
        check({nm, " count"}, longint'(fq.size()), 15);
        if (fq.size() > 0)
            check({nm, " first cyc"}, longint'(fq[0].c), longint'(first_c));
        for (int i = 0; i < ex.size() && i < fq.size(); i++) begin
            check($sformatf("%s x[%0d]", nm, i), fq[i].x, ex[i]);
            check($sformatf("%s y[%0d]", nm, i), fq[i].y, ey[i]);
            check($sformatf("%s w0[%0d]", nm, i), fq[i].w0, 16 - 4 * (ex[i] + ey[i]));
            check($sformatf("%s w1[%0d]", nm, i), fq[i].w1, swapped ? 4 * ey[i] : 4 * ex[i]);
            check($sformatf("%s w2[%0d]", nm, i), fq[i].w2, swapped ? 4 * ex[i] : 4 * ey[i]);
            check($sformatf("%s area[%0d]", nm, i), fq[i].area, 16);
        end
    endtask

    initial begin
        int t, s;
        i_frag_ready = 1'b1;
        tri_bus.i_dv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tri_bus.i_vertex_pixel[i][0] = '0;
            tri_bus.i_vertex_pixel[i][1] = '0;
        end
        tri_bus.i_vertex_z[0] = 12'd100;
        tri_bus.i_vertex_z[1] = 12'd200;
        tri_bus.i_vertex_z[2] = 12'd3000;
        for (int i = 0; i < 2; i++) begin
            tri_bus.i_bb_tl[i] = '0;
            tri_bus.i_bb_br[i] = '0;
        end

        repeat (3) tick();
        check("rst o_ready", longint'(tri_bus.o_ready), 1);
        check("rst o_busy", longint'(o_busy), 0);
        check("rst o_frag_dv", longint'(o_frag_dv), 0);
        check("rst o_tri_done", longint'(o_tri_done), 0);
        check("rst o_area", longint'(o_area), 0);
        check("rst o_w0", longint'(o_w[0]), 0);
        check("rst o_vertex_z0", longint'(o_vertex_z[0]), 0);
        rstn = 1'b1;
        tick();

        // 1: CCW right triangle, full-speed consumer
        fq.delete();
        s = done_cnt;
        send_tri(0, 0, 4, 0, 0, 4, 0, 0, 4, 4, t);
        wait_done("t1", s);
        check("t1 done cyc", longint'(done_cyc), longint'(t + 28));
        check_list("t1", t + 4, 1'b0);
        check("t1 z0", longint'(o_vertex_z[0]), 100);
        check("t1 z2", longint'(o_vertex_z[2]), 3000);

        // 2: same triangle, opposite winding
        fq.delete();
        s = done_cnt;
        send_tri(0, 0, 0, 4, 4, 0, 0, 0, 4, 4, t);
        wait_done("t2", s);
        check_list("t2", t + 4, 1'b1);

        // 3: degenerate (collinear) triangle
        fq.delete();
        s = done_cnt;
        send_tri(0, 0, 2, 2, 4, 4, 0, 0, 4, 4, t);
        tick();
        tick();
        check("t3 done at T+3", longint'(o_tri_done), 1);
        check("t3 ready at T+3", longint'(tri_bus.o_ready), 0);
        tick();
        check("t3 ready at T+4", longint'(tri_bus.o_ready), 1);
        check("t3 done count", longint'(done_cnt - s), 1);
        check("t3 frags", longint'(fq.size()), 0);

        // 4: back-pressure for 5 clks on the first fragment
        fq.delete();
        s = done_cnt;
        stall_cnt = 0;
        stab_err = 0;
        send_tri(0, 0, 4, 0, 0, 4, 0, 0, 4, 4, t);
        for (int n = 0; n < 20 && cyc < t + 4; n++) tick();
        i_frag_ready = 1'b0;
        repeat (5) tick();
        i_frag_ready = 1'b1;
        wait_done("t4", s);
        check("t4 done cyc", longint'(done_cyc), longint'(t + 33));
        check("t4 stall clks", longint'(stall_cnt), 5);
        check("t4 held stable", longint'(stab_err), 0);
        check_list("t4", t + 9, 1'b0);

        // 5: reset mid-triangle, then a fresh triangle
        s = done_cnt;
        send_tri(0, 0, 4, 0, 0, 4, 0, 0, 4, 4, t);
        for (int n = 0; n < 20 && cyc < t + 10; n++) tick();
        rstn = 1'b0;
        tick();
        check("t5 frag_dv after rst", longint'(o_frag_dv), 0);
        check("t5 ready after rst", longint'(tri_bus.o_ready), 1);
        check("t5 done after rst", longint'(o_tri_done), 0);
        rstn = 1'b1;
        repeat (5) tick();
        check("t5 no done pulse", longint'(done_cnt - s), 0);
        fq.delete();
        send_tri(0, 0, 4, 0, 0, 4, 0, 0, 4, 4, t);
        wait_done("t5b", s);
        check("t5b done cyc", longint'(done_cyc), longint'(t + 28));
        check_list("t5b", t + 4, 1'b0);

        // 6: empty bounding box
        fq.delete();
        s = done_cnt;
        send_tri(0, 0, 4, 0, 0, 4, 3, 3, 2, 3, t);
        wait_done("t6", s);
        check("t6 done cyc", longint'(done_cyc), longint'(t + 3));
        check("t6 frags", longint'(fq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
